// File: rtl/vend_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vend_seq_ctrl
// Description : Newspaper vending sequencer. Collects coin credit, runs the
//               req/ack handshake with the dispenser once credit covers
//               PRICE, and returns surplus or cancelled credit as 5-cent
//               change pulses. Holds the only credit register in the path.
//               Optional macro VEND_TIMEOUT_EN adds a dispense ack timeout
//               that refunds the full credit and pulses disp_fault.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_seq_ctrl #(
    parameter int PRICE      = 3,   // item price, 5-cent units
    parameter int MAX_CREDIT = 7,   // highest credit accepted, 5-cent units
    parameter int CREDIT_W   = 3,   // credit register width
    parameter int TIMEOUT    = 15   // dispense ack timeout, cycles
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                disp_fault
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_COLLECT  = 2'd1;
    localparam logic [1:0] c_ST_DISPENSE = 2'd2;
    localparam logic [1:0] c_ST_CHANGE   = 2'd3;

    // One extra bit so credit + coin can be compared against MAX_CREDIT
    // without wrapping.
    localparam logic [CREDIT_W:0]   c_MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   c_PRICE_W = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] c_PRICE_N = CREDIT_W'(PRICE);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_gap;
    logic                r_coin_reject;

    logic [CREDIT_W:0]   w_coin_val;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_remain;
    logic                w_coin_valid;
    logic                w_coin_seen;
    logic                w_accept;
    logic                w_reject;
    logic                w_last_pulse;
    logic                w_tmo_hit;

    // Coin decode and acceptance decision for the current cycle.
    always_comb begin
        w_coin_val   = '0;
        w_coin_valid = 1'b0;
        case (coin)
            2'b01: begin
                w_coin_val   = (CREDIT_W+1)'(1);
                w_coin_valid = 1'b1;
            end
            2'b10: begin
                w_coin_val   = (CREDIT_W+1)'(2);
                w_coin_valid = 1'b1;
            end
            default: begin
                w_coin_val   = '0;
                w_coin_valid = 1'b0;
            end
        endcase
        w_coin_seen  = (coin != 2'b00);
        w_sum        = {1'b0, r_credit} + w_coin_val;
        // Only reached in DISPENSE, where credit >= PRICE, so no underflow.
        w_remain     = r_credit - c_PRICE_N;
        // Coins are taken only while collecting; cancel beats a coin.
        w_accept     = w_coin_valid && (w_sum <= c_MAX_W) &&
                       ((r_state == c_ST_IDLE) ||
                        ((r_state == c_ST_COLLECT) && !cancel));
        w_reject     = w_coin_seen && !w_accept;
        w_last_pulse = (r_state == c_ST_CHANGE) && !r_gap &&
                       (r_credit == CREDIT_W'(1));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_sum >= c_PRICE_W) ? c_ST_DISPENSE : c_ST_COLLECT;
                end
            end
            c_ST_COLLECT: begin
                if (cancel) begin
                    w_state_nxt = c_ST_CHANGE;
                end else if (w_accept && (w_sum >= c_PRICE_W)) begin
                    w_state_nxt = c_ST_DISPENSE;
                end
            end
            c_ST_DISPENSE: begin
                if (disp_ack) begin
                    w_state_nxt = (w_remain != '0) ? c_ST_CHANGE : c_ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_ST_CHANGE;
                end
            end
            c_ST_CHANGE: begin
                if (w_last_pulse) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Credit, change-pulse spacing and reject pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_credit      <= '0;
            r_gap         <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_coin_reject <= w_reject;
            // gap restarts at 0 on every entry to CHANGE so the first
            // refund cycle is a pulse.
            r_gap         <= (r_state == c_ST_CHANGE) ? ~r_gap : 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_COLLECT: begin
                    if (w_accept) begin
                        r_credit <= w_sum[CREDIT_W-1:0];
                    end
                end
                c_ST_DISPENSE: begin
                    if (disp_ack) begin
                        r_credit <= w_remain;
                    end
                end
                c_ST_CHANGE: begin
                    if (!r_gap) begin
                        r_credit <= r_credit - CREDIT_W'(1);
                    end
                end
                default: r_credit <= r_credit;
            endcase
        end
    end

`ifdef VEND_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_disp_fault;

    // The count held here is the number of completed ack-less DISPENSE
    // cycles; the hit fires on the cycle that would make it TIMEOUT, and an
    // ack in that same cycle takes priority.
    assign w_tmo_hit = (r_state == c_ST_DISPENSE) && !disp_ack &&
                       ((r_tmo_cnt + c_TMO_W'(1)) == c_TMO_W'(TIMEOUT));

    // Dispense timeout counter; idles at zero outside DISPENSE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tmo_cnt    <= '0;
            r_disp_fault <= 1'b0;
        end else begin
            r_disp_fault <= w_tmo_hit;
            if (r_state != c_ST_DISPENSE) begin
                r_tmo_cnt <= '0;
            end else if (!disp_ack) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
        end
    end

    assign disp_fault = r_disp_fault;
`else
    logic w_unused_timeout;

    assign w_tmo_hit        = 1'b0;
    assign disp_fault       = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    // Moore outputs decoded from the current state.
    always_comb begin
        disp_req     = (r_state == c_ST_DISPENSE);
        busy         = (r_state == c_ST_DISPENSE) || (r_state == c_ST_CHANGE);
        change_pulse = (r_state == c_ST_CHANGE) && !r_gap;
    end

    assign credit      = r_credit;
    assign coin_reject = r_coin_reject;

endmodule
`default_nettype wire

// File: tb/tb_vend_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_seq_ctrl
// Description : Self-checking bench for vend_seq_ctrl. A transaction-level
//               model (credit, dispensing/refunding flags, refund phase)
//               predicts every output each cycle; directed scenarios add
//               fixed expectations. A second instance with PRICE=7 covers
//               the credit-overflow boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_seq_ctrl;

    localparam int PRICE      = 3;
    localparam int MAX_CREDIT = 7;
`ifdef VEND_TIMEOUT_EN
    localparam int TIMEOUT    = 15;
`endif

    logic       clock = 1'b0;
    logic       reset, cancel, disp_ack;
    logic [1:0] coin;
    logic       disp_req, change_pulse, coin_reject, busy, disp_fault;
    logic [2:0] credit;

    logic       reset7, cancel7, disp_ack7;
    logic [1:0] coin7;
    logic       disp_req7, change_pulse7, coin_reject7, busy7, disp_fault7;
    logic [2:0] credit7;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state.
    int m_credit = 0;
    bit m_disp   = 1'b0;
    bit m_refund = 1'b0;
    bit m_rej    = 1'b0;
    bit m_fault  = 1'b0;
    int m_phase  = 0;
    int m_wait   = 0;

    wire [7:0] dut_vec = {disp_req, change_pulse, coin_reject, busy, disp_fault, credit};

    always #5 clock = ~clock;

    vend_seq_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(3)) u_dut (
        .clock(clock), .reset(reset), .coin(coin), .cancel(cancel),
        .disp_ack(disp_ack), .disp_req(disp_req), .change_pulse(change_pulse),
        .coin_reject(coin_reject), .credit(credit), .busy(busy),
        .disp_fault(disp_fault)
    );

    vend_seq_ctrl #(.PRICE(7), .MAX_CREDIT(7), .CREDIT_W(3)) u_dut7 (
        .clock(clock), .reset(reset7), .coin(coin7), .cancel(cancel7),
        .disp_ack(disp_ack7), .disp_req(disp_req7), .change_pulse(change_pulse7),
        .coin_reject(coin_reject7), .credit(credit7), .busy(busy7),
        .disp_fault(disp_fault7)
    );

    function automatic logic [7:0] exp_vec();
        return {m_disp, (m_refund && (m_phase % 2 == 0)), m_rej,
                (m_disp || m_refund), m_fault, 3'(m_credit)};
    endfunction

    // Advance the model by one clock from the rules of the vending flow.
    task automatic model_update(input logic [1:0] c, input logic can,
                                input logic ack, input logic rst);
        int val;
        val     = (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : 0;
        m_rej   = 1'b0;
        m_fault = 1'b0;
        if (rst) begin
            m_credit = 0; m_disp = 0; m_refund = 0; m_phase = 0; m_wait = 0;
        end else if (m_disp) begin
            m_rej = (c != 2'd0);
            if (ack) begin
                m_credit -= PRICE;
                m_disp    = 1'b0;
                m_refund  = (m_credit > 0);
                m_phase   = 0;
            end else begin
                m_wait++;
`ifdef VEND_TIMEOUT_EN
                if (m_wait == TIMEOUT) begin
                    m_fault = 1'b1; m_disp = 1'b0; m_refund = 1'b1; m_phase = 0;
                end
`endif
            end
        end else if (m_refund) begin
            m_rej = (c != 2'd0);
            if (m_phase % 2 == 0) begin
                m_credit--;
                if (m_credit == 0) m_refund = 1'b0;
            end
            m_phase++;
        end else if (can && m_credit > 0) begin
            m_rej    = (c != 2'd0);
            m_refund = 1'b1;
            m_phase  = 0;
        end else if (c != 2'd0) begin
            if (val == 0 || m_credit + val > MAX_CREDIT) begin
                m_rej = 1'b1;
            end else begin
                m_credit += val;
                if (m_credit >= PRICE) begin
                    m_disp = 1'b1;
                    m_wait = 0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, settle.
    task automatic step(input logic [1:0] c, input logic can,
                        input logic ack, input logic rst);
        coin = c; cancel = can; disp_ack = ack; reset = rst;
        @(posedge clock);
        model_update(c, can, ack, rst);
        #1;
    endtask

    task automatic test_reset();
        coin7 = 2'd0; cancel7 = 1'b0; disp_ack7 = 1'b0; reset7 = 1'b1;
        step(2'd0, 1'b0, 1'b0, 1'b1);
        n_chk++;
        if (dut_vec !== 8'h00) $display("FAIL reset_state: got %h want 00", dut_vec);
        else n_pass++;
        step(2'd0, 1'b1, 1'b1, 1'b0);
        n_chk++;
        if (dut_vec !== 8'h00) $display("FAIL idle_ignores_cancel_ack: got %h want 00", dut_vec);
        else n_pass++;
    endtask

    task automatic test_exact_price();
        logic [1:0] cs [5] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        bit         ak [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int         cr [5] = '{1, 2, 3, 3, 0};
        bit         dr [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        step(2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(cs[i], 1'b0, ak[i], 1'b0);
            n_chk++;
            if ({disp_req, credit} !== {dr[i], 3'(cr[i])})
                $display("FAIL exact_price[%0d]: got req=%b credit=%0d want req=%b credit=%0d",
                         i, disp_req, credit, dr[i], cr[i]);
            else n_pass++;
            n_chk++;
            if ({coin_reject, change_pulse} !== 2'b00)
                $display("FAIL exact_price_quiet[%0d]: got rej=%b pulse=%b want 0 0",
                         i, coin_reject, change_pulse);
            else n_pass++;
        end
        n_chk++;
        if (busy !== 1'b0) $display("FAIL exact_price_idle: got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_change();
        logic [1:0] cs [6] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        bit         ak [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int         cr [6] = '{2, 4, 1, 0, 0, 0};
        bit         pl [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        step(2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(cs[i], 1'b0, ak[i], 1'b0);
            n_chk++;
            if ({change_pulse, credit} !== {pl[i], 3'(cr[i])})
                $display("FAIL change[%0d]: got pulse=%b credit=%0d want pulse=%b credit=%0d",
                         i, change_pulse, credit, pl[i], cr[i]);
            else n_pass++;
            n_chk++;
            if (dut_vec !== exp_vec())
                $display("FAIL change_model[%0d]: got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_cancel();
        logic [1:0] cs [5] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        bit         cn [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int         cr [5] = '{2, 2, 1, 1, 0};
        bit         pl [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bit         bz [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        step(2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(cs[i], cn[i], 1'b0, 1'b0);
            n_chk++;
            if ({disp_req, change_pulse, busy, credit} !== {1'b0, pl[i], bz[i], 3'(cr[i])})
                $display("FAIL cancel[%0d]: got req=%b pulse=%b busy=%b credit=%0d want 0 %b %b %0d",
                         i, disp_req, change_pulse, busy, credit, pl[i], bz[i], cr[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reject();
        logic [1:0] cs [8] = '{2'd3, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
        bit         cn [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bit         ak [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bit         rj [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int         cr [8] = '{0, 1, 3, 3, 0, 1, 1, 0};
        step(2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(cs[i], cn[i], ak[i], 1'b0);
            n_chk++;
            if ({coin_reject, credit} !== {rj[i], 3'(cr[i])})
                $display("FAIL reject[%0d]: got rej=%b credit=%0d want rej=%b credit=%0d",
                         i, coin_reject, credit, rj[i], cr[i]);
            else n_pass++;
            n_chk++;
            if (dut_vec !== exp_vec())
                $display("FAIL reject_model[%0d]: got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_dispense();
        step(2'd0, 1'b0, 1'b0, 1'b1);
        step(2'd2, 1'b0, 1'b0, 1'b0);
        step(2'd2, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (disp_req !== 1'b1) $display("FAIL mid_disp_setup: got req=%b want 1", disp_req);
        else n_pass++;
        step(2'd0, 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (dut_vec !== 8'h00) $display("FAIL mid_disp_reset: got %h want 00", dut_vec);
        else n_pass++;
        step(2'd0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (dut_vec !== 8'h00) $display("FAIL mid_disp_after: got %h want 00", dut_vec);
        else n_pass++;
    endtask

    task automatic test_overflow_price7();
        logic [1:0] cs [6] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
        int         cr [6] = '{2, 4, 6, 6, 7, 7};
        bit         rj [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bit         dr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        reset7 = 1'b1; coin7 = 2'd0;
        step(2'd0, 1'b0, 1'b0, 1'b0);
        reset7 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            coin7 = cs[i];
            step(2'd0, 1'b0, 1'b0, 1'b0);
            n_chk++;
            if ({disp_req7, coin_reject7, credit7} !== {dr[i], rj[i], 3'(cr[i])})
                $display("FAIL price7[%0d]: got req=%b rej=%b credit=%0d want req=%b rej=%b credit=%0d",
                         i, disp_req7, coin_reject7, credit7, dr[i], rj[i], cr[i]);
            else n_pass++;
        end
        coin7 = 2'd0; reset7 = 1'b1;
        step(2'd0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({disp_req7, change_pulse7, busy7, disp_fault7, credit7} !== 7'b0)
            $display("FAIL price7_reset: got req=%b pulse=%b busy=%b fault=%b credit=%0d want all 0",
                     disp_req7, change_pulse7, busy7, disp_fault7, credit7);
        else n_pass++;
        reset7 = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses;
`ifdef VEND_TIMEOUT_EN
        for (int pass = 0; pass < 2; pass++) begin
            step(2'd0, 1'b0, 1'b0, 1'b1);
            step(2'd2, 1'b0, 1'b0, 1'b0);
            step(2'd2, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < TIMEOUT; i++) begin
                step(2'd0, 1'b0, (pass == 1) && (i == TIMEOUT - 1), 1'b0);
                n_chk++;
                if (disp_fault !== ((pass == 0) && (i == TIMEOUT - 1)))
                    $display("FAIL timeout_fault[%0d.%0d]: got %b want %b",
                             pass, i, disp_fault, (pass == 0) && (i == TIMEOUT - 1));
                else n_pass++;
            end
            n_chk++;
            if (credit !== ((pass == 0) ? 3'd4 : 3'd1))
                $display("FAIL timeout_credit[%0d]: got %0d want %0d", pass, credit,
                         (pass == 0) ? 4 : 1);
            else n_pass++;
            pulses = 0;
            for (int k = 0; k < 20; k++) begin
                if (!busy) break;
                pulses += int'(change_pulse);
                step(2'd0, 1'b0, 1'b0, 1'b0);
            end
            n_chk++;
            if ({busy, credit, 32'(pulses)} !== {1'b0, 3'd0, 32'((pass == 0) ? 4 : 1)})
                $display("FAIL timeout_refund[%0d]: got busy=%b credit=%0d pulses=%0d want 0 0 %0d",
                         pass, busy, credit, pulses, (pass == 0) ? 4 : 1);
            else n_pass++;
        end
`else
        step(2'd0, 1'b0, 1'b0, 1'b1);
        step(2'd2, 1'b0, 1'b0, 1'b0);
        step(2'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            step(2'd0, 1'b0, 1'b0, 1'b0);
            n_chk++;
            if ({disp_req, disp_fault} !== 2'b10)
                $display("FAIL wait_forever[%0d]: got req=%b fault=%b want 1 0",
                         i, disp_req, disp_fault);
            else n_pass++;
        end
        step(2'd0, 1'b0, 1'b1, 1'b0);
        pulses = int'(change_pulse);
        n_chk++;
        if ({credit, 32'(pulses)} !== {3'd1, 32'd1})
            $display("FAIL late_ack: got credit=%0d pulse=%0d want 1 1", credit, pulses);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [1:0] c;
        logic       can, ack, rst;
        step(2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            c   = 2'($urandom_range(0, 3));
            can = ($urandom_range(0, 7) == 0);
            ack = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step(c, can, ack, rst);
            n_chk++;
            if (dut_vec !== exp_vec())
                $display("FAIL random[%0d]: got %h want %h (coin=%0d cancel=%b ack=%b rst=%b)",
                         i, dut_vec, exp_vec(), c, can, ack, rst);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_exact_price();
        test_change();
        test_cancel();
        test_reject();
        test_reset_mid_dispense();
        test_overflow_price7();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_seq_ctrl.md
Name: vend_seq_ctrl

Overview:
Sequencer for the newspaper vending datapath. Accumulates coin credit, drives a req/ack handshake to the dispensing mechanism when credit reaches PRICE, then pays back surplus or cancelled credit as 5-cent change pulses. Sits between the coin acceptor and both the dispenser and change hopper. Owns the only credit register in the vending path.

Parameters:
PRICE, 3, item price in 5-cent units (3 = 15 cents); 1 <= PRICE <= MAX_CREDIT
MAX_CREDIT, 7, highest credit accepted, in 5-cent units
CREDIT_W, 3, credit register width; must hold MAX_CREDIT
TIMEOUT, 15, dispense ack timeout in cycles (used only with VEND_TIMEOUT_EN)

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
coin  in  2  coin sampled every cycle: 00 none, 01 5c, 10 10c, 11 invalid
cancel  in  1  level, sampled per cycle; requests refund of all credit
disp_ack  in  1  dispenser done; sampled only in DISPENSE
disp_req  out  1  dispense request, high for the whole DISPENSE state
change_pulse  out  1  one pulse = return one 5c coin
coin_reject  out  1  one-cycle pulse, the cycle after a coin was refused
credit  out  CREDIT_W  current credit, 5-cent units
busy  out  1  high in DISPENSE or CHANGE
disp_fault  out  1  one-cycle pulse on dispense timeout; constant 0 without VEND_TIMEOUT_EN

Behaviour:
- Reset: state IDLE, credit 0, disp_req 0, change_pulse 0, coin_reject 0, busy 0, disp_fault 0, gap 0, timeout counter 0. Reset in any state aborts at once: no dispense completes and no refund is issued.
- Coin value: 01 -> 1, 10 -> 2. Coin 11 is always rejected. Any coin seen in DISPENSE or CHANGE is rejected.
- A coin is also rejected when credit + value > MAX_CREDIT. A rejected coin leaves credit unchanged and sets coin_reject = 1 for exactly the next cycle.
- States: IDLE, COLLECT, DISPENSE, CHANGE. Outputs are Moore: disp_req = (state == DISPENSE); busy = (state is DISPENSE or CHANGE).
- IDLE: credit is 0.
  - Accepted coin -> credit = value, next state COLLECT; go straight to DISPENSE instead if value >= PRICE.
  - cancel is ignored in IDLE.
- COLLECT:
  - Accepted coin -> credit += value; next state DISPENSE if the new credit >= PRICE, else stay in COLLECT.
  - cancel -> next state CHANGE (full refund), gap = 0.
  - coin and cancel in the same cycle: cancel wins and the coin is rejected.
- DISPENSE: disp_req is asserted the cycle after the qualifying coin, i.e. 1-cycle latency.
  - disp_ack = 1 -> credit -= PRICE; next state CHANGE if the remainder > 0, else IDLE. disp_req drops the following cycle.
  - cancel is ignored in DISPENSE.
- CHANGE: gap toggles every cycle and change_pulse = (state == CHANGE && !gap), so pulses are 1 cycle high, 1 cycle low.
  - Each pulse decrements credit by 1, in the same posedge that ends the pulse.
  - When credit reaches 0 -> IDLE, with no trailing low cycle.
  - cancel is ignored in CHANGE.
- All arithmetic is unsigned in CREDIT_W+1 bits for the overflow compare. credit never underflows and never exceeds MAX_CREDIT.

Optional Feature:
Macro VEND_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to DISPENSE and increments every DISPENSE cycle without disp_ack.
  - When it reaches TIMEOUT, disp_fault pulses for 1 cycle and the state goes to CHANGE with credit unreduced (full refund).
  - disp_ack in the same cycle the count reaches TIMEOUT: ack wins, normal completion, no fault.
- Undefined: no counter, DISPENSE waits indefinitely, disp_fault tied 0.

Test Plan:
- Reset, then coin 01,01,01 on consecutive cycles -> credit 1,2,3; disp_req high the next cycle; disp_ack 2 cycles later -> credit 0, IDLE, no change_pulse, coin_reject never set.
- coin 10,10 -> credit 4, DISPENSE; ack -> credit 1, CHANGE; exactly one change_pulse -> credit 0 -> IDLE.
- coin 10 then cancel -> credit 2, then change_pulse pattern 1,0,1 with credit 2->1->0, then IDLE; disp_req never asserted.
- coin 11 in IDLE, coin 01 during DISPENSE, coin 01 together with cancel in COLLECT -> a coin_reject pulse for each, credit unchanged by the rejected coin; cancel still refunds.
- With PRICE=7, MAX_CREDIT=7: credit 6 then coin 10 -> rejected (8 > 7); coin 01 -> credit 7 -> DISPENSE. Reset asserted mid-DISPENSE -> next cycle disp_req 0, credit 0, IDLE, no change_pulse.
- VEND_TIMEOUT_EN, PRICE=3: coin 10,10 (credit 4), hold disp_ack 0 -> disp_fault after 15 DISPENSE cycles, then 4 change_pulses, credit 0. Repeat with ack on the 15th cycle -> no fault, 1 change_pulse.
